// File: rtl/sensor_hub_sched.sv
// sensor_hub_sched: round-robin scheduler sharing one anomaly detector among NCH sensor channels.
// Build option SCHED_PRIO0_EN: channel 0 pre-empts round-robin arbitration whenever it requests.
//
// state | meaning
// IDLE  | waiting for hub_enable and at least one channel request
// ISSUE | latched sample presented to the detector until det_ready
// WAIT  | waiting for the detector result, bounded by TIMEOUT cycles
// DONE  | result published on ai_signal/ai_chan, ai_valid high for one cycle
module sensor_hub_sched #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   hub_enable,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*DW-1:0]      ch_data,
    output logic [NCH-1:0]         ch_gnt,
    output logic                   det_valid,
    input  logic                   det_ready,
    output logic [DW-1:0]          det_data,
    output logic [$clog2(NCH)-1:0] det_chan,
    input  logic                   det_res_valid,
    input  logic [1:0]             det_res,
    output logic [1:0]             ai_signal,
    output logic                   ai_valid,
    output logic [$clog2(NCH)-1:0] ai_chan,
    output logic                   busy
);
    localparam int CW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] RES_NODATA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [DW-1:0] data_q, data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] last_grant_q, last_grant_d;
    logic [1:0]    ai_signal_q, ai_signal_d;
    logic [CW-1:0] ai_chan_q, ai_chan_d;

    logic          pick_found;
    logic [CW-1:0] pick_idx;
    logic [CW-1:0] cand;

    // Search starts just after the last granted channel; first hit wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(last_grant_q) + k) % NCH);
            if (!pick_found && ch_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
`ifdef SCHED_PRIO0_EN
        if (ch_req[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        data_d       = data_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        ai_signal_d  = ai_signal_q;
        ai_chan_d    = ai_chan_q;
        ch_gnt       = '0;

        case (state_q)
            IDLE: begin
                if (hub_enable && pick_found) begin
                    chan_d  = pick_idx;
                    data_d  = ch_data[int'(pick_idx)*DW +: DW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (det_ready) begin
                    ch_gnt[chan_q] = 1'b1;
                    timer_d        = TW'(TIMEOUT - 1);
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the terminal-count cycle still wins.
                if (det_res_valid) begin
                    ai_signal_d = (det_res == 2'b11) ? RES_NODATA : det_res;
                    ai_chan_d   = chan_q;
                    state_d     = DONE;
                end else if (timer_q == '0) begin
                    ai_signal_d = RES_NODATA;
                    ai_chan_d   = chan_q;
                    state_d     = DONE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DONE: begin
`ifdef SCHED_PRIO0_EN
                if (chan_q != '0) begin
                    last_grant_d = chan_q;
                end
`else
                last_grant_d = chan_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            chan_q       <= '0;
            data_q       <= '0;
            timer_q      <= '0;
            last_grant_q <= CW'(NCH - 1);
            ai_signal_q  <= RES_NODATA;
            ai_chan_q    <= '0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            data_q       <= data_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            ai_signal_q  <= ai_signal_d;
            ai_chan_q    <= ai_chan_d;
        end
    end

    assign det_valid = (state_q == ISSUE);
    assign det_data  = data_q;
    assign det_chan  = chan_q;
    assign ai_signal = ai_signal_q;
    assign ai_valid  = (state_q == DONE);
    assign ai_chan   = ai_chan_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_hub_sched.sv
// Directed bench for sensor_hub_sched: arbitration order, handshake stalls, timeout, result mapping, reset.
// Grant-order expectations follow SCHED_PRIO0_EN when the bench is built with it defined.
module tb_sensor_hub_sched;
    localparam int NCH     = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              hub_enable;
    logic [NCH-1:0]    ch_req;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_gnt;
    logic              det_valid;
    logic              det_ready;
    logic [DW-1:0]     det_data;
    logic [1:0]        det_chan;
    logic              det_res_valid;
    logic [1:0]        det_res;
    logic [1:0]        ai_signal;
    logic              ai_valid;
    logic [1:0]        ai_chan;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [NCH-1:0] exp_order [4];
    logic [NCH-1:0] g;
    int             n;
    logic           seen;

    always #5 clk = ~clk;

    sensor_hub_sched #(.NCH(NCH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hub_enable    (hub_enable),
        .ch_req        (ch_req),
        .ch_data       (ch_data),
        .ch_gnt        (ch_gnt),
        .det_valid     (det_valid),
        .det_ready     (det_ready),
        .det_data      (det_data),
        .det_chan      (det_chan),
        .det_res_valid (det_res_valid),
        .det_res       (det_res),
        .ai_signal     (ai_signal),
        .ai_valid      (ai_valid),
        .ai_chan       (ai_chan),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_gnt(input int max_cyc, output logic [NCH-1:0] gv, output int nc);
        gv = '0;
        nc = 0;
        while (nc < max_cyc && gv == '0) begin
            tick();
            nc++;
            gv = ch_gnt;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
`ifdef SCHED_PRIO0_EN
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        reset_n       = 1'b1;
        hub_enable    = 1'b0;
        ch_req        = '0;
        ch_data       = '0;
        det_ready     = 1'b0;
        det_res_valid = 1'b0;
        det_res       = 2'b00;
        #1 reset_n    = 1'b0;
        repeat (3) tick();

        chk("rst_gnt",       32'(ch_gnt),    32'h0);
        chk("rst_det_valid", 32'(det_valid), 32'h0);
        chk("rst_det_data",  32'(det_data),  32'h0);
        chk("rst_det_chan",  32'(det_chan),  32'h0);
        chk("rst_ai_signal", 32'(ai_signal), 32'h2);
        chk("rst_ai_valid",  32'(ai_valid),  32'h0);
        chk("rst_ai_chan",   32'(ai_chan),   32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        reset_n = 1'b1;
        tick();

        // single request on ch0, result 01 two cycles after the grant
        ch_data    = {8'h44, 8'h33, 8'h22, 8'hA1};
        hub_enable = 1'b1;
        det_ready  = 1'b1;
        ch_req     = 4'b0001;
        tick();
        chk("t1_gnt",       32'(ch_gnt),    32'h1);
        chk("t1_det_valid", 32'(det_valid), 32'h1);
        chk("t1_det_data",  32'(det_data),  32'hA1);
        chk("t1_det_chan",  32'(det_chan),  32'h0);
        chk("t1_busy",      32'(busy),      32'h1);
        ch_req = 4'b0000;
        tick();
        chk("t1_wait_valid", 32'(det_valid), 32'h0);
        chk("t1_wait_gnt",   32'(ch_gnt),    32'h0);
        tick();
        det_res_valid = 1'b1;
        det_res       = 2'b01;
        tick();
        det_res_valid = 1'b0;
        chk("t1_ai_valid",  32'(ai_valid),  32'h1);
        chk("t1_ai_signal", 32'(ai_signal), 32'h1);
        chk("t1_ai_chan",   32'(ai_chan),   32'h0);
        tick();
        chk("t1_ai_valid_end", 32'(ai_valid),  32'h0);
        chk("t1_busy_end",     32'(busy),      32'h0);
        chk("t1_ai_hold",      32'(ai_signal), 32'h1);

        // all channels requesting, immediate results: order and 4-cycle spacing
        ch_req        = 4'b1111;
        det_res_valid = 1'b1;
        det_res       = 2'b00;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(8, g, n);
            chk("t2_gnt_order", 32'(g), 32'(exp_order[i]));
            if (i > 0) chk("t2_spacing", 32'(n), 32'd4);
        end
        ch_req = 4'b0000;
        tick();
        tick();
        chk("t2_ai_valid",  32'(ai_valid),  32'h1);
        chk("t2_ai_chan",   32'(ai_chan),   32'h0);
        chk("t2_ai_signal", 32'(ai_signal), 32'h0);
        det_res_valid = 1'b0;
        tick();
        chk("t2_busy_end", 32'(busy), 32'h0);

        // detector never answers: timeout after exactly TIMEOUT WAIT cycles
        ch_req = 4'b0100;
        tick();
        chk("t3_gnt", 32'(ch_gnt), 32'h4);
        ch_req = 4'b0000;
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("t3_pre_ai_valid", 32'(ai_valid),  32'h0);
        chk("t3_pre_busy",     32'(busy),      32'h1);
        chk("t3_pre_signal",   32'(ai_signal), 32'h0);
        tick();
        chk("t3_ai_valid",  32'(ai_valid),  32'h1);
        chk("t3_ai_signal", 32'(ai_signal), 32'h2);
        chk("t3_ai_chan",   32'(ai_chan),   32'h2);
        tick();
        chk("t3_busy_end",     32'(busy),     32'h0);
        chk("t3_ai_valid_end", 32'(ai_valid), 32'h0);

        // result on the terminal-count cycle beats the timeout
        ch_req = 4'b0010;
        tick();
        chk("t4_gnt", 32'(ch_gnt), 32'h2);
        ch_req = 4'b0000;
        tick();
        repeat (TIMEOUT - 1) tick();
        det_res_valid = 1'b1;
        det_res       = 2'b01;
        #1;
        chk("t4_pre_ai_valid", 32'(ai_valid), 32'h0);
        tick();
        det_res_valid = 1'b0;
        chk("t4_ai_signal", 32'(ai_signal), 32'h1);
        chk("t4_ai_valid",  32'(ai_valid),  32'h1);
        chk("t4_ai_chan",   32'(ai_chan),   32'h1);
        tick();

        // det_ready low for 5 cycles while hub_enable drops; sample stays latched
        ch_data    = {8'h5C, 8'h33, 8'h22, 8'hA1};
        ch_req     = 4'b1000;
        det_ready  = 1'b0;
        hub_enable = 1'b1;
        tick();
        hub_enable      = 1'b0;
        ch_req          = 4'b1010;
        ch_data[31:24]  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_stall_valid", 32'(det_valid), 32'h1);
            chk("t5_stall_data",  32'(det_data),  32'h5C);
            chk("t5_stall_chan",  32'(det_chan),  32'h3);
            chk("t5_stall_gnt",   32'(ch_gnt),    32'h0);
            tick();
        end
        det_ready = 1'b1;
        #1;
        chk("t5_gnt", 32'(ch_gnt), 32'h8);
        ch_req = 4'b0010;
        tick();
        det_res_valid = 1'b1;
        det_res       = 2'b11;
        tick();
        det_res_valid = 1'b0;
        chk("t5_map11",   32'(ai_signal), 32'h2);
        chk("t5_ai_chan", 32'(ai_chan),   32'h3);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (ch_gnt != '0 || busy) seen = 1'b1;
        end
        chk("t5_gated", 32'(seen), 32'h0);
        hub_enable = 1'b1;
        wait_gnt(4, g, n);
        chk("t5_regrant",     32'(g), 32'h2);
        chk("t5_regrant_lat", 32'(n), 32'd1);
        ch_req        = 4'b0000;
        det_res_valid = 1'b1;
        det_res       = 2'b00;
        repeat (3) tick();
        det_res_valid = 1'b0;

        // reset during WAIT aborts the transaction; ch0 is first afterwards
        ch_req = 4'b0100;
        tick();
        chk("t6_gnt", 32'(ch_gnt), 32'h4);
        ch_req = 4'b0000;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_busy",      32'(busy),      32'h0);
        chk("t6_det_valid", 32'(det_valid), 32'h0);
        chk("t6_det_data",  32'(det_data),  32'h0);
        chk("t6_det_chan",  32'(det_chan),  32'h0);
        chk("t6_ai_signal", 32'(ai_signal), 32'h2);
        chk("t6_ai_valid",  32'(ai_valid),  32'h0);
        chk("t6_ai_chan",   32'(ai_chan),   32'h0);
        chk("t6_gnt_rst",   32'(ch_gnt),    32'h0);
        tick();
        ch_req = 4'b1111;
        tick();
        reset_n = 1'b1;
        wait_gnt(4, g, n);
        chk("t6_first_gnt", 32'(g), 32'h1);
        chk("t6_first_lat", 32'(n), 32'd1);
        ch_req        = 4'b0000;
        det_res_valid = 1'b1;
        repeat (3) tick();
        det_res_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
